vfb_triple_sched: RTL

Triple-buffer frame scheduler for the DDR3 video frame store. It sits beside the DMA block, between the input-side write channel (HDMI RX or CMOS path) and the output-side read channel (HDMI TX). It tracks which of three DDR frame buffers is being written, which is being displayed and which holds the newest complete frame. On each input and output vsync it hands both channels fresh base addresses, so the writer never overwrites the frame being read and the reader always gets the latest complete frame.

---
 rtl/vfb_triple_sched.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vfb_triple_sched.sv
// ---------------------------------------------------------------------------
// vfb_triple_sched
//
// Triple-buffer frame scheduler for the DDR3 video frame store. Tracks which
// of three frame buffers is being written, which is being displayed and which
// holds the newest complete frame. It hands fresh base addresses to the write
// and read DMA channels on every input / output vsync.
//
// Ports
//   clk          scheduler clock (memory-side user clock)
//   rst_n        asynchronous active-low reset
//   enable       run control; while low the scheduler holds its reset state
//   wr_vs        input-side vsync (asynchronous)
//   rd_vs        output-side vsync (asynchronous)
//   wr_base      write-channel base address
//   rd_base      read-channel base address
//   wr_start     one-cycle pulse, wr_base (re)issued
//   rd_start     one-cycle pulse, rd_base (re)issued
//   ready_valid  a complete, not yet displayed frame is waiting
//   frame_cnt    completed input frames (saturating)
//   drop_cnt     completed frames overwritten before display (saturating)
//   repeat_cnt   output frames that re-showed the previous buffer (saturating)
//
// CNT_W sets the statistics counter width; it defaults to 16.
// ---------------------------------------------------------------------------

// Vsync synchronizer plus registered edge detector. Produces a one-cycle
// event two cycles after the new level is first sampled.
module vfb_vs_edge #(
  parameter logic VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_i,
  output logic ev_o
);

  logic meta_q;
  logic sync_q;
  logic lvl_dly_q;
  logic lvl;

  // Polarity-normalised level: 1 means "vsync active".
  assign lvl = VS_POL ? sync_q : ~sync_q;

  // Synchronizer resets to the inactive level so no edge is seen at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= ~VS_POL;
      sync_q    <= ~VS_POL;
      lvl_dly_q <= 1'b0;
    end else begin
      meta_q    <= vs_i;
      sync_q    <= meta_q;
      lvl_dly_q <= lvl;
    end
  end

  assign ev_o = lvl & ~lvl_dly_q;

endmodule


module vfb_triple_sched #(
  parameter int                ADDR_W       = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 28'h000_0000,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h020_0000,
  parameter logic              VS_POL       = 1'b1,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_vs,
  input  logic              rd_vs,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              wr_start,
  output logic              rd_start,
  output logic              ready_valid,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  localparam logic [ADDR_W-1:0] BASE0 = BASE_ADDR;
  localparam logic [ADDR_W-1:0] BASE1 = BASE_ADDR + FRAME_STRIDE;
  localparam logic [ADDR_W-1:0] BASE2 = BASE_ADDR + FRAME_STRIDE + FRAME_STRIDE;

  localparam logic [1:0]       WR_IDX_RST = 2'd0;
  localparam logic [1:0]       RD_IDX_RST = 2'd1;
  localparam logic [1:0]       RY_IDX_RST = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Base address as a three-way constant mux; no multiplier needed.
  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
    case (idx)
      2'd1:    return BASE1;
      2'd2:    return BASE2;
      default: return BASE0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // -------------------------------------------------------------------------
  // Vsync event generation
  // -------------------------------------------------------------------------
  logic wr_ev;
  logic rd_ev;

  vfb_vs_edge #(.VS_POL(VS_POL)) u_wr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .vs_i  (wr_vs),
    .ev_o  (wr_ev)
  );

  vfb_vs_edge #(.VS_POL(VS_POL)) u_rd_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .vs_i  (rd_vs),
    .ev_o  (rd_ev)
  );

  // -------------------------------------------------------------------------
  // Scheduler state
  // -------------------------------------------------------------------------
  logic [1:0]       wr_idx_q,    wr_idx_d;
  logic [1:0]       rd_idx_q,    rd_idx_d;
  logic [1:0]       rdy_idx_q,   rdy_idx_d;
  logic             rdy_vld_q,   rdy_vld_d;
  logic             wr_active_q, wr_active_d;
  logic             wr_start_q,  wr_start_d;
  logic             rd_start_q,  rd_start_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q,   rep_cnt_d;

  logic             wr_take;
  logic [1:0]       wr_free_idx;

  // The buffer that is neither being written nor displayed. Indices are
  // always a permutation subset of {0,1,2}, so this fits in two bits.
  assign wr_free_idx = 2'd3 - wr_idx_q - rd_idx_q;

  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    rdy_idx_d   = rdy_idx_q;
    rdy_vld_d   = rdy_vld_q;
    wr_active_d = wr_active_q;
    wr_start_d  = 1'b0;
    rd_start_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    wr_take     = 1'b0;

    if (!enable) begin
      wr_idx_d    = WR_IDX_RST;
      rd_idx_d    = RD_IDX_RST;
      rdy_idx_d   = RY_IDX_RST;
      rdy_vld_d   = 1'b0;
      wr_active_d = 1'b0;
      frame_cnt_d = '0;
      drop_cnt_d  = '0;
      rep_cnt_d   = '0;
    end else begin
      wr_take = wr_ev & wr_active_q;

      // The first edge after enable only closes a partial frame.
      if (wr_ev && !wr_active_q) begin
        wr_active_d = 1'b1;
        wr_start_d  = 1'b1;
      end

      if (wr_take) begin
        if (rdy_vld_q) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
        rdy_idx_d   = wr_idx_q;
        rdy_vld_d   = 1'b1;
        frame_cnt_d = sat_inc(frame_cnt_q);
        wr_idx_d    = wr_free_idx;
        wr_start_d  = 1'b1;
      end

      if (rd_ev) begin
        rd_start_d = 1'b1;
        if (wr_take) begin
          // Coincident events: the reader takes the frame just completed.
          rd_idx_d  = wr_idx_q;
          rdy_vld_d = 1'b0;
        end else if (rdy_vld_q) begin
          rd_idx_d  = rdy_idx_q;
          rdy_vld_d = 1'b0;
        end else begin
          rep_cnt_d = sat_inc(rep_cnt_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q    <= WR_IDX_RST;
      rd_idx_q    <= RD_IDX_RST;
      rdy_idx_q   <= RY_IDX_RST;
      rdy_vld_q   <= 1'b0;
      wr_active_q <= 1'b0;
      wr_start_q  <= 1'b0;
      rd_start_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      rep_cnt_q   <= '0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rdy_idx_q   <= rdy_idx_d;
      rdy_vld_q   <= rdy_vld_d;
      wr_active_q <= wr_active_d;
      wr_start_q  <= wr_start_d;
      rd_start_q  <= rd_start_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  // Indices only move together with their start pulse, so decoding the base
  // straight from the index register keeps the bases stable between pulses.
  assign wr_base     = base_of(wr_idx_q);
  assign rd_base     = base_of(rd_idx_q);
  assign wr_start    = wr_start_q;
  assign rd_start    = rd_start_q;
  assign ready_valid = rdy_vld_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign repeat_cnt  = rep_cnt_q;

  a_wr_rd_distinct : assert property (@(posedge clk) disable iff (!rst_n)
    wr_idx_q != rd_idx_q);

  a_ready_distinct : assert property (@(posedge clk) disable iff (!rst_n)
    rdy_vld_q |-> (rdy_idx_q != wr_idx_q && rdy_idx_q != rd_idx_q));

endmodule
